// File: rtl/ms_register_file_pkg.sv
// Shared definitions for the master-slave register file: write operation encodings.
package ms_regfile_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

endpackage

// File: rtl/ms_register_cell.sv
// One master/slave register pair: master captures on rising cl, slave publishes on falling cl.
module ms_register_cell #(
   parameter int WIDTH = 16
) (
   input  logic             cl,
   input  logic             rst_n,
   input  logic             cap,
   input  logic [WIDTH-1:0] nxt,
   input  logic             pub,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] master_q, master_d;
   logic [WIDTH-1:0] slave_q, slave_d;

   // master next value
   always_comb begin
      master_d = master_q;
      if (cap) begin
         master_d = nxt;
      end else begin
         master_d = master_q;
      end
   end

   // slave next value
   always_comb begin
      slave_d = slave_q;
      if (pub) begin
         slave_d = master_q;
      end else begin
         slave_d = slave_q;
      end
   end

   // master capture on rising edge
   always_ff @(posedge cl or negedge rst_n) begin
      if (!rst_n) begin
         master_q <= '0;
      end else begin
         master_q <= master_d;
      end
   end

   // slave publish on falling edge
   always_ff @(negedge cl or negedge rst_n) begin
      if (!rst_n) begin
         slave_q <= '0;
      end else begin
         slave_q <= slave_d;
      end
   end

   assign q = slave_q;

endmodule

// File: rtl/ms_register_file.sv
// Master-slave register file: addressed write with LOAD/INC/CLR, published half a cycle
// after capture, two combinational read ports and a one-cycle INC wrap flag.
module ms_register_file
   import ms_regfile_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int NREGS = 4,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             cl,
   input  logic             rst_n,
   input  logic             st,
   input  logic [1:0]       op,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] d,
   input  logic [AW-1:0]    ra0,
   input  logic [AW-1:0]    ra1,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic             pending,
   output logic             wrap
);

   logic [WIDTH-1:0] slave_s [NREGS];
   logic [NREGS-1:0] cap_s, pub_s;
   logic [WIDTH-1:0] cur_s, nxt_s;
   logic             wr_en_s, inc_wrap_s, pending_s;

   logic [AW-1:0]    wa_q, wa_d;
   logic             tog_p_q, tog_p_d;
   logic             tog_n_q, tog_n_d;
   logic             inc_wrap_q, inc_wrap_d;
   logic             wrap_q, wrap_d;

   // Pending is the mismatch between a posedge toggle and its negedge echo, so it is
   // high exactly from the capturing posedge to the following negedge.
   assign pending_s = tog_p_q ^ tog_n_q;

   // write decode, INC source (published value) and per-register capture/publish enables
   always_comb begin
      cur_s   = '0;
      wr_en_s = 1'b0;
      if (int'(wa) < NREGS) begin
         cur_s   = slave_s[wa];
         wr_en_s = st && (op != OP_HOLD);
      end else begin
         cur_s   = '0;
         wr_en_s = 1'b0;
      end
      case (op)
         OP_LOAD: nxt_s = d;
         OP_INC:  nxt_s = cur_s + {{(WIDTH-1){1'b0}}, 1'b1};
         OP_CLR:  nxt_s = '0;
         default: nxt_s = cur_s;
      endcase
      inc_wrap_s = wr_en_s && (op == OP_INC) && (&cur_s);
      for (int i = 0; i < NREGS; i++) begin
         cap_s[i] = wr_en_s && (int'(wa) == i);
         pub_s[i] = pending_s && (int'(wa_q) == i);
      end
   end

   // posedge-side control next values
   always_comb begin
      tog_p_d    = tog_p_q ^ wr_en_s;
      inc_wrap_d = inc_wrap_s;
      if (wr_en_s) begin
         wa_d = wa;
      end else begin
         wa_d = wa_q;
      end
   end

   // negedge-side control next values
   always_comb begin
      tog_n_d = tog_p_q;
      wrap_d  = pending_s && inc_wrap_q;
   end

   // capture-side control state
   always_ff @(posedge cl or negedge rst_n) begin
      if (!rst_n) begin
         tog_p_q    <= 1'b0;
         wa_q       <= '0;
         inc_wrap_q <= 1'b0;
      end else begin
         tog_p_q    <= tog_p_d;
         wa_q       <= wa_d;
         inc_wrap_q <= inc_wrap_d;
      end
   end

   // publish-side control state
   always_ff @(negedge cl or negedge rst_n) begin
      if (!rst_n) begin
         tog_n_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         tog_n_q <= tog_n_d;
         wrap_q  <= wrap_d;
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_cell
      ms_register_cell #(.WIDTH(WIDTH)) u_cell (
         .cl    (cl),
         .rst_n (rst_n),
         .cap   (cap_s[g]),
         .nxt   (nxt_s),
         .pub   (pub_s[g]),
         .q     (slave_s[g])
      );
   end

   assign q0      = slave_s[ra0];
   assign q1      = slave_s[ra1];
   assign pending = pending_s;
   assign wrap    = wrap_q;

endmodule
